// File: rtl/lif_pkg.sv
// Shared types, product codes and the membrane fit() function for lif_integrator.
// fit() saturates when LIF_SATURATE_EN is defined and wraps otherwise.
package lif_pkg;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        LEAK = 2'd1,
        FIRE = 2'd2
    } lif_state_e;

    localparam logic [1:0] PROD_ZERO = 2'b00;
    localparam logic [1:0] PROD_POS  = 2'b01;
    localparam logic [1:0] PROD_NEG  = 2'b11;

    // Reduces a wide signed value to the w-bit signed membrane range.
    function automatic logic signed [63:0] fit(input logic signed [63:0] x, input int w);
`ifdef LIF_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
`else
        return (x <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/lif_membrane_update.sv
// Combinational membrane datapath: leak-and-add in LEAK, threshold subtract in FIRE.
module lif_membrane_update #(
    parameter int W     = 8,
    parameter int SW    = 5,
    parameter int XW    = 13,
    parameter int SHIFT = 2
) (
    input  logic [W-1:0]  u_i,
    input  logic [SW-1:0] sum_i,
    input  logic [W-1:0]  thr_i,
    input  logic          fire_i,
    output logic [W-1:0]  u_next_o
);
    import lif_pkg::*;

    logic signed [XW-1:0] u_x;
    logic signed [XW-1:0] sum_x;
    logic signed [XW-1:0] thr_x;
    logic signed [XW-1:0] res_x;

    // Widen operands so the intermediate result never overflows before fit().
    always_comb begin
        u_x   = {{(XW-W){u_i[W-1]}}, u_i};
        sum_x = {{(XW-SW){sum_i[SW-1]}}, sum_i};
        thr_x = {{(XW-W){1'b0}}, thr_i};
        if (fire_i) begin
            res_x = u_x - thr_x;
        end else begin
            res_x = u_x - (u_x >>> SHIFT) + sum_x;
        end
        u_next_o = W'(fit(64'(res_x), W));
    end

endmodule

// File: rtl/lif_integrator.sv
// Leaky integrate-and-fire core: sums N_INPUTS signed products, then leaks and fires.
// Optional LIF_SATURATE_EN makes membrane updates saturate instead of wrap.
module lif_integrator #(
    parameter int N_INPUTS = 8,
    parameter int W        = 8,
    parameter int SHIFT    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   prod,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] threshold,
    output logic         spike,
    output logic         spike_valid,
    output logic [W-1:0] membrane
);
    import lif_pkg::*;

    localparam int CW = $clog2(N_INPUTS);
    localparam int SW = CW + 2;
    localparam int XW = W + SW;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_INPUTS - 1);

    lif_state_e        state_q, state_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [SW-1:0]     prod_x;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      u_q, u_d;
    logic [W-1:0]      u_upd;
    logic              spike_q, spike_d;
    logic              spike_valid_q, spike_valid_d;
    logic              xfer;
    logic              fire_ok;

    lif_membrane_update #(
        .W     (W),
        .SW    (SW),
        .XW    (XW),
        .SHIFT (SHIFT)
    ) u_update (
        .u_i      (u_q),
        .sum_i    (sum_q),
        .thr_i    (threshold),
        .fire_i   (state_q == FIRE),
        .u_next_o (u_upd)
    );

    // Next-state, accumulator and membrane control.
    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        cnt_d         = cnt_q;
        u_d           = u_q;
        spike_d       = spike_q;
        spike_valid_d = 1'b0;
        xfer          = in_valid && (state_q == ACC);
        fire_ok       = $signed({u_q[W-1], u_q}) >= $signed({1'b0, threshold});

        // Code 10 is not emitted upstream but still decodes as -2.
        case (prod)
            PROD_ZERO: prod_x = {SW{1'b0}};
            PROD_POS:  prod_x = {{(SW-1){1'b0}}, 1'b1};
            PROD_NEG:  prod_x = {SW{1'b1}};
            default:   prod_x = {{(SW-1){1'b1}}, 1'b0};
        endcase

        case (state_q)
            ACC: begin
                if (xfer) begin
                    sum_d = sum_q + prod_x;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = LEAK;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            LEAK: begin
                u_d     = u_upd;
                sum_d   = {SW{1'b0}};
                cnt_d   = {CW{1'b0}};
                state_d = FIRE;
            end
            FIRE: begin
                if (fire_ok) begin
                    spike_d = 1'b1;
                    u_d     = u_upd;
                end else begin
                    spike_d = 1'b0;
                    u_d     = u_q;
                end
                spike_valid_d = 1'b1;
                state_d       = ACC;
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ACC;
            sum_q         <= {SW{1'b0}};
            cnt_q         <= {CW{1'b0}};
            u_q           <= {W{1'b0}};
            spike_q       <= 1'b0;
            spike_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            u_q           <= u_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
        end
    end

    assign in_ready    = (state_q == ACC);
    assign spike       = spike_q;
    assign spike_valid = spike_valid_q;
    assign membrane    = u_q;

endmodule

// File: tb/tb_lif_integrator.sv
// Self-checking bench for lif_integrator: integer reference model plus directed literal checks.
module tb_lif_integrator;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SHIFT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [1:0]   prod;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] threshold;
    logic         spike;
    logic         spike_valid;
    logic [W-1:0] membrane;

    logic         r7, v7, rdy7, spk7, sv7;
    logic [1:0]   p7;
    logic [7:0]   t7, mem7;

    lif_integrator #(.N_INPUTS(N), .W(W), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset), .prod(prod), .in_valid(in_valid), .in_ready(in_ready),
        .threshold(threshold), .spike(spike), .spike_valid(spike_valid), .membrane(membrane)
    );

    lif_integrator #(.N_INPUTS(4), .W(8), .SHIFT(7)) dut7 (
        .clk(clk), .reset(r7), .prod(p7), .in_valid(v7), .in_ready(rdy7),
        .threshold(t7), .spike(spk7), .spike_valid(sv7), .membrane(mem7)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int fit_m(input int x);
        int hi;
        int lo;
        logic signed [W-1:0] t;
        hi = 2 ** (W - 1) - 1;
        lo = -(2 ** (W - 1));
`ifdef LIF_SATURATE_EN
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
`else
        t = x[W-1:0];
        if (hi < lo) return x;
        return int'(t);
`endif
    endfunction

    // Reference model: timestep = N accepted products, then two busy cycles.
    int  m_sum = 0, m_cnt = 0, m_u = 0, m_busy = 0, exp_mem = 0;
    bit  exp_ready = 1'b1, exp_sv = 1'b0, exp_spike = 1'b0, xfer_seen = 1'b0;
    initial forever begin
        @(posedge clk);
        xfer_seen = in_valid && in_ready;
        if (reset) begin
            m_sum = 0; m_cnt = 0; m_u = 0; m_busy = 0;
            exp_sv = 1'b0; exp_spike = 1'b0;
        end else begin
            exp_sv = 1'b0;
            if (m_busy == 2) begin
                m_u = fit_m(m_u - (m_u >>> SHIFT) + m_sum);
                m_sum = 0;
                m_busy = 1;
            end else if (m_busy == 1) begin
                if (m_u >= int'(threshold)) begin
                    exp_spike = 1'b1;
                    m_u = fit_m(m_u - int'(threshold));
                end else begin
                    exp_spike = 1'b0;
                end
                exp_sv = 1'b1;
                m_busy = 0;
            end else if (in_valid) begin
                m_sum += int'($signed(prod));
                m_cnt++;
                if (m_cnt == N) begin
                    m_cnt = 0;
                    m_busy = 2;
                end
            end
        end
        exp_ready = (m_busy == 0);
        exp_mem = m_u;
    end

    // Per-cycle comparison against the model.
    bit chk_en = 1'b0;
    int pulses = 0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", int'(in_ready), int'(exp_ready));
            check("spike_valid", int'(spike_valid), int'(exp_sv));
            if (exp_sv) check("spike", int'(spike), int'(exp_spike));
            check("membrane", int'($signed(membrane)), exp_mem);
        end
        if (spike_valid === 1'b1) pulses++;
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("reset membrane", int'($signed(membrane)), 0);
        check("reset spike_valid", int'(spike_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
    endtask

    task automatic drive(input logic [1:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            prod = p;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic step(input string tag, input logic [1:0] p, input int exp_spk, input int exp_m);
        int lat;
        drive(p, N);
        lat = 1;
        while (spike_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 3);
        check({tag, " spike"}, int'(spike), exp_spk);
        check({tag, " membrane"}, int'($signed(membrane)), exp_m);
        @(negedge clk);
    endtask

    // Saturate/wrap scenario on a SHIFT=7 instance running alongside.
    bit done7 = 1'b0;
    initial begin
        int p7cnt;
        int exp_last;
`ifdef LIF_SATURATE_EN
        exp_last = 127;
`else
        exp_last = -128;
`endif
        r7 = 1'b1; v7 = 1'b0; p7 = 2'b01; t7 = 8'd255;
        @(negedge clk);
        r7 = 1'b0; v7 = 1'b1;
        p7cnt = 0;
        for (int c = 0; c < 400 && p7cnt < 32; c++) begin
            @(negedge clk);
            if (sv7) begin
                p7cnt++;
                check("t4 no spike", int'(spk7), 0);
                if (p7cnt == 31) check("t4 step31 membrane", int'($signed(mem7)), 124);
                if (p7cnt == 32) check("t4 step32 membrane", int'($signed(mem7)), exp_last);
            end
        end
        check("t4 timesteps", p7cnt, 32);
        v7 = 1'b0;
        done7 = 1'b1;
    end

    initial begin
        int p0;
        int pat;
        reset = 1'b1; in_valid = 1'b0; prod = 2'b00; threshold = 8'd5;
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        do_reset();
        step("t1", 2'b01, 0, 4);
        step("t2", 2'b01, 1, 2);
        do_reset();
        step("t3a", 2'b11, 0, -4);
        step("t3b", 2'b00, 0, -3);

        do_reset();
        p0 = pulses;
        drive(2'b01, 2);
        do_reset();
        check("t6 no early pulse", pulses - p0, 0);
        step("t6", 2'b01, 0, 4);
        check("t6 single pulse", pulses - p0, 1);

        // Random phase: held-valid incrementing pattern first, then gaps and resets.
        pat = 0;
        for (int c = 0; c < 900; c++) begin
            if (c % 60 == 0) begin
                case ($urandom_range(0, 4))
                    0:       threshold = 8'd0;
                    1:       threshold = 8'd127;
                    2:       threshold = 8'(128 + $urandom_range(0, 127));
                    default: threshold = 8'($urandom_range(1, 20));
                endcase
            end
            if (!in_valid || xfer_seen) begin
                in_valid = (c < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (in_valid) begin
                    prod = 2'(pat);
                    pat++;
                end
            end
            reset = (c >= 200) && ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < 1000 && !done7; i++) @(negedge clk);
        check("t4 finished", int'(done7), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
